// File: rtl/cmsdk_rst_pkg.sv
// Shared constants for the Cortex-M0 reset sequencer: FSM state encodings
// and the bit positions of the sticky reset-cause register.
package cmsdk_rst_pkg;

   // FSM state encodings (2-bit, all four codes used)
   localparam logic [1:0] S_POR       = 2'd0;
   localparam logic [1:0] S_SYSHOLD   = 2'd1;
   localparam logic [1:0] S_RUN       = 2'd2;
   localparam logic [1:0] S_SYSASSERT = 2'd3;

   typedef logic [1:0] rst_state_t;

   // RSTINFO bit positions
   localparam int RI_SYSREQ = 0;
   localparam int RI_WDOG   = 1;
   localparam int RI_LOCKUP = 2;
   localparam int RI_W      = 3;

endpackage

// File: rtl/cmsdk_rst_hold_counter.sv
// Hold-time counter shared by the power-on and system reset phases.
// clr loads zero (priority over inc); inc adds one but saturates at all-ones
// so the count never wraps. match compares the current count to target.
module cmsdk_rst_hold_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] target,
   output logic             match
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins, otherwise saturating increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match = (cnt_q == target);

endmodule

// File: rtl/cmsdk_mcu_rstctrl.sv
// Reset sequencer for the Cortex-M0 subsystem. After RST drops it releases
// PORESETn, then HRESETn. In normal running, a system-level request
// (SYSRESETREQ, watchdog, or lockup when enabled) pulses HRESETn low for
// SYS_CYCLES cycles and records the cause in the sticky RSTINFO register.
// Every output comes straight from a flop.
module cmsdk_mcu_rstctrl
   import cmsdk_rst_pkg::*;
#(
   parameter int POR_CYCLES = 16,
   parameter int SYS_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            SYSRESETREQ,
   input  logic            WDOGRESREQ,
   input  logic            LOCKUP,
   input  logic            LOCKUPRESET_EN,
   input  logic            RSTINFO_CLR,
   output logic            PORESETn,
   output logic            HRESETn,
   output logic [RI_W-1:0] RSTINFO
);

   // The counter is cleared on entry to each hold phase, so the phase ends on
   // the edge where the count has reached (cycles - 1).
   localparam logic [CNT_W-1:0] POR_TGT = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] SYS_TGT = CNT_W'(SYS_CYCLES - 1);

   rst_state_t       state_q;
   rst_state_t       state_d;
   logic             poresetn_q;
   logic             poresetn_d;
   logic             hresetn_q;
   logic             hresetn_d;
   logic [RI_W-1:0]  rstinfo_q;
   logic [RI_W-1:0]  rstinfo_d;

   logic             cnt_clr;
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt_target;
   logic             cnt_match;

   logic [RI_W-1:0]  cause;
   logic             req;

   // Active request causes, one bit per RSTINFO position
   always_comb begin
      cause            = '0;
      cause[RI_SYSREQ] = SYSRESETREQ;
      cause[RI_WDOG]   = WDOGRESREQ;
      cause[RI_LOCKUP] = LOCKUP & LOCKUPRESET_EN;
   end

   assign req = |cause;

   cmsdk_rst_hold_counter #(
      .CNT_W (CNT_W)
   ) u_hold_cnt (
      .clk    (CLK),
      .rst    (RST),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .target (cnt_target),
      .match  (cnt_match)
   );

   // Sequencer next-state, next reset levels and hold-counter control
   always_comb begin
      state_d    = state_q;
      poresetn_d = poresetn_q;
      hresetn_d  = hresetn_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      cnt_target = SYS_TGT;

      case (state_q)
         S_POR: begin
            cnt_target = POR_TGT;
            poresetn_d = 1'b0;
            hresetn_d  = 1'b0;
            if (cnt_match) begin
               state_d    = S_SYSHOLD;
               poresetn_d = 1'b1;
               cnt_clr    = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end

         S_SYSHOLD: begin
            poresetn_d = 1'b1;
            hresetn_d  = 1'b0;
            if (cnt_match) begin
               state_d   = S_RUN;
               hresetn_d = 1'b1;
               cnt_clr   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end

         S_RUN: begin
            poresetn_d = 1'b1;
            hresetn_d  = 1'b1;
            if (req) begin
               state_d   = S_SYSASSERT;
               hresetn_d = 1'b0;
               cnt_clr   = 1'b1;
            end
         end

         S_SYSASSERT: begin
            // Requests here are ignored; a level still high is seen in S_RUN
            poresetn_d = 1'b1;
            hresetn_d  = 1'b0;
            if (cnt_match) begin
               state_d   = S_RUN;
               hresetn_d = 1'b1;
               cnt_clr   = 1'b1;
            end else begin
               cnt_inc = 1'b1;
            end
         end

         default: begin
            state_d    = S_POR;
            poresetn_d = 1'b0;
            hresetn_d  = 1'b0;
            cnt_clr    = 1'b1;
         end
      endcase
   end

   // Sticky cause register: causes are only captured in S_RUN, and a cause
   // being set beats a simultaneous clear for its own bit.
   always_comb begin
      rstinfo_d = RSTINFO_CLR ? '0 : rstinfo_q;
      if (state_q == S_RUN) begin
         rstinfo_d = rstinfo_d | cause;
      end
   end

   // State and registered outputs; RST overrides everything at the edge
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_POR;
         poresetn_q <= 1'b0;
         hresetn_q  <= 1'b0;
         rstinfo_q  <= '0;
      end else begin
         state_q    <= state_d;
         poresetn_q <= poresetn_d;
         hresetn_q  <= hresetn_d;
         rstinfo_q  <= rstinfo_d;
      end
   end

   assign PORESETn = poresetn_q;
   assign HRESETn  = hresetn_q;
   assign RSTINFO  = rstinfo_q;

endmodule

// File: tb/tb_cmsdk_mcu_rstctrl.sv
// Directed bench for cmsdk_mcu_rstctrl with default parameters (16/4).
// Each vector holds the inputs applied before one clock edge and the
// outputs expected just after that edge.
module tb_cmsdk_mcu_rstctrl;

   typedef struct {
      logic       rst;
      logic       sysreq;
      logic       wdog;
      logic       lockup;
      logic       lock_en;
      logic       clr;
      logic       exp_por;
      logic       exp_h;
      logic [2:0] exp_info;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       sysreq;
   logic       wdog;
   logic       lockup;
   logic       lock_en;
   logic       info_clr;
   logic       poresetn;
   logic       hresetn;
   logic [2:0] rstinfo;

   int n_cmp;
   int n_fail;
   int vec_no;

   vec_t vq[$];

   cmsdk_mcu_rstctrl #(
      .POR_CYCLES (16),
      .SYS_CYCLES (4),
      .CNT_W      (8)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
      .SYSRESETREQ    (sysreq),
      .WDOGRESREQ     (wdog),
      .LOCKUP         (lockup),
      .LOCKUPRESET_EN (lock_en),
      .RSTINFO_CLR    (info_clr),
      .PORESETn       (poresetn),
      .HRESETn        (hresetn),
      .RSTINFO        (rstinfo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %b want %b", name, vec_no, act, exp);
      end
   endtask

   // Drive one vector, clock once, compare all outputs
   task automatic apply(input vec_t v);
      rst      = v.rst;
      sysreq   = v.sysreq;
      wdog     = v.wdog;
      lockup   = v.lockup;
      lock_en  = v.lock_en;
      info_clr = v.clr;
      @(posedge clk);
      #1;
      chk("PORESETn", {2'b00, poresetn}, {2'b00, v.exp_por});
      chk("HRESETn",  {2'b00, hresetn},  {2'b00, v.exp_h});
      chk("RSTINFO",  rstinfo,           v.exp_info);
      vec_no++;
   endtask

   task automatic add(input logic r, input logic s, input logic w, input logic l,
                      input logic le, input logic c, input logic ep, input logic eh,
                      input logic [2:0] ei);
      vec_t v;
      v.rst = r; v.sysreq = s; v.wdog = w; v.lockup = l; v.lock_en = le; v.clr = c;
      v.exp_por = ep; v.exp_h = eh; v.exp_info = ei;
      vq.push_back(v);
   endtask

   // Power-on from RST release: PORESETn rises at edge 16, HRESETn at edge 20.
   // Requests raised during the sequence are ignored and not recorded.
   task automatic por_sequence(input int n_edges, input logic noisy);
      vec_t v;
      for (int k = 1; k <= n_edges; k++) begin
         v.rst      = 1'b0;
         v.sysreq   = 1'b0;
         v.wdog     = noisy && (k >= 5) && (k <= 7);
         v.lockup   = 1'b0;
         v.lock_en  = 1'b0;
         v.clr      = 1'b0;
         v.exp_por  = (k >= 16);
         v.exp_h    = (k >= 20);
         v.exp_info = 3'b000;
         if (noisy && k == 18) v.sysreq = 1'b1;
         apply(v);
      end
   endtask

   initial begin
      vec_t v;
      n_cmp    = 0;
      n_fail   = 0;
      vec_no   = 0;
      rst      = 1'b1;
      sysreq   = 1'b0;
      wdog     = 1'b0;
      lockup   = 1'b0;
      lock_en  = 1'b0;
      info_clr = 1'b0;

      // ---- reset held for 3 edges ----
      for (int i = 0; i < 3; i++) begin
         v = '{rst:1'b1, sysreq:1'b1, wdog:1'b1, lockup:1'b0, lock_en:1'b0, clr:1'b0,
               exp_por:1'b0, exp_h:1'b0, exp_info:3'b000};
         apply(v);
      end

      // ---- power-on sequence, then idle in run ----
      por_sequence(25, 1'b0);

      // ---- vector table: request scenarios in S_RUN ----
      //   rst sys wdg lck len clr | por h  info
      // SYSRESETREQ one-cycle pulse: 4 cycles low, high at e+4
      add(0, 1, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 1, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 1, 3'b001);
      // clear alone
      add(0, 0, 0, 0, 0, 1,   1, 1, 3'b000);
      // lockup without enable: no reset, nothing recorded
      add(0, 0, 0, 1, 0, 0,   1, 1, 3'b000);
      add(0, 0, 0, 1, 0, 0,   1, 1, 3'b000);
      // lockup enabled plus watchdog at one edge; sysreq during hold is ignored
      add(0, 0, 1, 1, 1, 0,   1, 0, 3'b110);
      add(0, 1, 0, 0, 1, 0,   1, 0, 3'b110);
      add(0, 1, 0, 0, 1, 0,   1, 0, 3'b110);
      add(0, 0, 0, 0, 1, 0,   1, 0, 3'b110);
      add(0, 0, 0, 0, 1, 0,   1, 1, 3'b110);
      add(0, 0, 0, 0, 0, 0,   1, 1, 3'b110);
      add(0, 0, 0, 0, 0, 1,   1, 1, 3'b000);
      // set 001, then clear and watchdog at the same edge -> 010
      add(0, 1, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 1, 3'b001);
      add(0, 0, 1, 0, 0, 1,   1, 0, 3'b010);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b010);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b010);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b010);
      add(0, 0, 0, 0, 0, 0,   1, 1, 3'b010);
      // clear with no cause leaves 000, HRESETn stays high
      add(0, 0, 0, 0, 0, 1,   1, 1, 3'b000);
      add(0, 0, 0, 0, 0, 0,   1, 1, 3'b000);
      // RST during the system hold: request at e, RST at e+2
      add(0, 1, 0, 0, 0, 0,   1, 0, 3'b001);
      add(0, 0, 0, 0, 0, 0,   1, 0, 3'b001);
      add(1, 0, 0, 0, 0, 0,   0, 0, 3'b000);

      foreach (vq[i]) apply(vq[i]);

      // ---- full power-on sequence repeats; requests during it are ignored ----
      por_sequence(22, 1'b1);

      // ---- SYSRESETREQ held high: 4 low / 1 high, PORESETn never drops ----
      for (int j = 0; j < 15; j++) begin
         v = '{rst:1'b0, sysreq:1'b1, wdog:1'b0, lockup:1'b0, lock_en:1'b0, clr:1'b0,
               exp_por:1'b1, exp_h:((j % 5) == 4), exp_info:3'b001};
         apply(v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
